// File: rtl/alu_pkg.sv
// Shared opcode/state encodings for the sequenced ALU stage.
package alu_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Status flag generation: Z/N derived from the result, C/V supplied by the datapath.
module alu_flag_gen #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             v_in,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  // Flags are pure functions of the result about to be registered
  always_comb begin
    z = (y == '0);
    n = y[WIDTH-1];
    c = c_in;
    v = v_in;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequenced ALU: single-cycle logic/add/sub, one-bit-per-cycle shifts and
// shift-and-add multiply, with valid/ready handshakes on both sides.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  state_e             state, state_d;
  op_e                op_in, op_q;
  logic [WIDTH-1:0]   work;      // shift data, or remaining multiplier bits
  logic [2*WIDTH-1:0] mcand;     // multiplicand, shifted left each step
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [SHW-1:0]     shamt;

  logic [WIDTH-1:0]   sh_nxt;
  logic               sh_c;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     sum, dif;

  logic               done_ld;
  logic [WIDTH-1:0]   res_y;
  logic               res_c, res_v;
  logic               z_d, n_d, c_d, v_d;

  assign op_in = op_e'(op);
  assign shamt = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} - {1'b0, b};

  // One iteration of the shift / multiply datapath
  always_comb begin
    sh_nxt  = work;
    sh_c    = 1'b0;
    acc_nxt = acc;
    if (op_q == OP_SLL)      {sh_c, sh_nxt} = {work, 1'b0};
    else if (op_q == OP_SRL) {sh_nxt, sh_c} = {1'b0, work};
    if (work[0]) acc_nxt = acc + mcand;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state and result selection; done_ld marks entry into DONE
  always_comb begin
    state_d   = state;
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    done_ld   = 1'b0;
    res_y     = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          case (op_in)
            OP_AND: begin done_ld = 1'b1; res_y = a & b; end
            OP_OR:  begin done_ld = 1'b1; res_y = a | b; end
            OP_XOR: begin done_ld = 1'b1; res_y = a ^ b; end
            OP_ADD: begin
              done_ld = 1'b1;
              res_y   = sum[WIDTH-1:0];
              res_c   = sum[WIDTH];
              res_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              done_ld = 1'b1;
              res_y   = dif[WIDTH-1:0];
              res_c   = ~dif[WIDTH];   // no borrow
              res_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL, OP_SRL: begin
              if (shamt == '0) begin done_ld = 1'b1; res_y = a; end
              else state_d = ST_BUSY;
            end
            default: state_d = ST_BUSY;  // OP_MUL
          endcase
          if (done_ld) state_d = ST_DONE;
        end
      end
      ST_BUSY: begin
        if (cnt == CW'(1)) begin
          done_ld = 1'b1;
          state_d = ST_DONE;
          if (op_q == OP_MUL) begin
            res_y = acc_nxt[WIDTH-1:0];
            res_c = |acc_nxt[2*WIDTH-1:WIDTH];
          end else begin
            res_y = sh_nxt;
            res_c = sh_c;
          end
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture on accept, then one shift / multiply step per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_AND;
      work  <= '0;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == ST_IDLE) begin
      if (in_valid) begin
        op_q  <= op_in;
        work  <= (op_in == OP_MUL) ? b : a;
        mcand <= {{WIDTH{1'b0}}, a};
        acc   <= '0;
        cnt   <= (op_in == OP_MUL) ? CW'(WIDTH) : {{(CW-SHW){1'b0}}, shamt};
      end
    end else if (state == ST_BUSY) begin
      cnt <= cnt - CW'(1);
      if (op_q == OP_MUL) begin
        work  <= work >> 1;
        mcand <= mcand << 1;
        acc   <= acc_nxt;
      end else begin
        work  <= sh_nxt;
      end
    end
  end

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .y    (res_y),
    .c_in (res_c),
    .v_in (res_v),
    .z    (z_d),
    .n    (n_d),
    .c    (c_d),
    .v    (v_d)
  );

  // Result and flags change only when entering DONE (or on reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      y      <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (done_ld) begin
      y      <= res_y;
      flag_z <= z_d;
      flag_n <= n_d;
      flag_c <= c_d;
      flag_v <= v_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized + directed self-checking bench for alu_op_sequencer.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [15:0] a, b, y;
  logic        flag_z, flag_n, flag_c, flag_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: arithmetic straight from the op definitions
  task automatic ref_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] w,
                        output logic [15:0] r, output logic c, output logic v, output int lat);
    logic [31:0] p;
    int s, n;
    c = 1'b0; v = 1'b0; lat = 1;
    n = int'(w[3:0]);
    case (o)
      3'd0: r = x & w;
      3'd1: r = x | w;
      3'd2: r = x ^ w;
      3'd3: begin
        p = {16'h0, x} + {16'h0, w};
        r = p[15:0]; c = p[16];
        s = int'($signed(x)) + int'($signed(w));
        v = (s > 32767) || (s < -32768);
      end
      3'd4: begin
        r = x - w; c = (x >= w);
        s = int'($signed(x)) - int'($signed(w));
        v = (s > 32767) || (s < -32768);
      end
      3'd5: begin
        p = {16'h0, x} << n;
        r = p[15:0]; c = (n != 0) ? p[16] : 1'b0;
        lat = (n == 0) ? 1 : n + 1;
      end
      3'd6: begin
        r = x >> n; c = (n != 0) ? x[n-1] : 1'b0;
        lat = (n == 0) ? 1 : n + 1;
      end
      default: begin
        p = {16'h0, x} * {16'h0, w};
        r = p[15:0]; c = (p[31:16] != 16'h0);
        lat = 17;
      end
    endcase
  endtask

  // Issue one op, measure latency, check result/flags, hold, then release
  task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] w,
                        input int hold, input string nm);
    logic [15:0] er;
    logic ec, ev;
    int elat, l, g;
    bit rdy_bad, hold_bad;
    ref_op(o, x, w, er, ec, ev, elat);
    g = 0;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    chk({nm, " ready_before"}, in_ready, 1);
    op = o; a = x; b = w; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
    l = 1; rdy_bad = 0;
    while (!out_valid && l <= 40) begin
      if (in_ready) rdy_bad = 1;
      out_ready = 1'($urandom);  // ignored while out_valid=0
      @(posedge clk); #1; l++;
    end
    out_ready = 1'b0;
    chk({nm, " latency"}, l, elat);
    chk({nm, " in_ready_low"}, {rdy_bad, in_ready}, 2'b00);
    chk({nm, " y"}, y, er);
    chk({nm, " znc v"}, {flag_z, flag_n, flag_c, flag_v}, {er == 16'h0, er[15], ec, ev});
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || y !== er || in_ready) hold_bad = 1;
    end
    if (hold > 0) chk({nm, " hold"}, hold_bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " release"}, {in_ready, out_valid}, 2'b10);
  endtask

  typedef struct { logic [15:0] r; logic c; logic v; } res_t;
  res_t q[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", {in_ready, out_valid, y, flag_z, flag_n, flag_c, flag_v}, {2'b10, 16'h0, 4'h0});
    rst = 1'b0;

    // Reset while a multiply is in progress
    op = 3'd7; a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mul busy", {in_ready, out_valid}, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("reset mid mul", {in_ready, out_valid, y, flag_z, flag_n, flag_c, flag_v}, {2'b10, 16'h0, 4'h0});
    repeat (20) @(posedge clk);
    #1;
    chk("no output after abort", out_valid, 0);

    // Directed cases
    run_op(3'd1, 16'h00F0, 16'h0F0F, 3, "or");
    run_op(3'd3, 16'h7FFF, 16'h0001, 0, "add ovf");
    run_op(3'd4, 16'h0003, 16'h0005, 0, "sub borrow");
    run_op(3'd4, 16'h8000, 16'h0001, 0, "sub ovf");
    run_op(3'd3, 16'hFFFF, 16'h0001, 0, "add carry");
    run_op(3'd5, 16'h8001, 16'd4, 1, "sll4");
    run_op(3'd6, 16'h0003, 16'd1, 0, "srl1");
    run_op(3'd5, 16'hA5A5, 16'h0000, 0, "sll0");
    run_op(3'd5, 16'h0001, 16'h000F, 0, "sll15");
    run_op(3'd6, 16'h8000, 16'hFFFF, 0, "srl15");
    run_op(3'd7, 16'h0100, 16'h0100, 2, "mul ovf");
    run_op(3'd7, 16'd12, 16'd11, 0, "mul small");
    run_op(3'd7, 16'hFFFF, 16'hFFFF, 0, "mul max");
    run_op(3'd2, 16'hFFFF, 16'hFFFF, 0, "xor zero");
    run_op(3'd0, 16'hF0F0, 16'hFF00, 0, "and");

    // Randomized single ops
    for (int k = 0; k < 40; k++)
      run_op(3'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), "rand");

    // Back-to-back: in_valid held high, out_ready pulsed randomly
    begin
      int accepts, results, cyc, bad;
      bit will_acc, will_pop, seen;
      res_t e;
      int lat;
      accepts = 0; results = 0; cyc = 0; bad = 0; seen = 0;
      op = 3'($urandom); a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
      while (results < 30 && cyc < 5000) begin
        if (in_ready && out_valid) bad++;
        if (out_valid && !seen && q.size() > 0) begin
          chk("b2b y", y, q[0].r);
          chk("b2b cv", {flag_c, flag_v}, {q[0].c, q[0].v});
          seen = 1;
        end
        out_ready = 1'($urandom);
        will_acc = in_valid && in_ready;
        will_pop = out_valid && out_ready;
        if (will_acc) begin
          ref_op(op, a, b, e.r, e.c, e.v, lat);
          q.push_back(e);
        end
        @(posedge clk); #1; cyc++;
        if (will_acc) begin
          accepts++;
          if (in_ready) bad++;  // a second accept would follow immediately
          op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
        end
        if (will_pop) begin
          if (q.size() > 0) void'(q.pop_front());
          else bad++;
          results++; seen = 0;
        end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b done in budget", results, 30);
      chk("b2b accept count", accepts, results + q.size());
      chk("b2b handshake rules", bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
